// File: rtl/reset_sequencer_if.sv
// Bundle of the signals between the reset sequencer and the rest of the GPU.
//
// Signals:
//   pll_locked      - PLL lock flag, asynchronous to clk (into sequencer)
//   btn_reset       - raw active-high board reset button, bouncy (into sequencer)
//   periph_reset    - active-high reset for memory/video peripherals (from sequencer)
//   core_reset      - active-high reset for the GPU core (from sequencer)
//   ready           - full release sequence completed (from sequencer)
//   lock_loss_count - saturating count of lock losses after release began
//   state_dbg       - current sequencer state encoding, for debug/checkers
//
// Handshake: there is no valid/ready transfer on this bundle. Inputs are level
// signals sampled every clk edge through synchronizers; outputs are levels
// driven straight from flops and may be sampled at any time.
interface reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             btn_reset;
    logic             periph_reset;
    logic             core_reset;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_count;
    logic [2:0]       state_dbg;

    // Environment side: drives the PLL flag and button, observes resets.
    modport master (
        output pll_locked,
        output btn_reset,
        input  periph_reset,
        input  core_reset,
        input  ready,
        input  lock_loss_count,
        input  state_dbg
    );

    // Sequencer side.
    modport slave (
        input  pll_locked,
        input  btn_reset,
        output periph_reset,
        output core_reset,
        output ready,
        output lock_loss_count,
        output state_dbg
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset generator fed by the main PLL lock flag and the board button.
// Releases peripherals first, then the GPU core, then raises ready. Any loss
// of lock or a debounced button press sends everything back into reset.
//
// Ports:
//   clk   - 50 MHz PLL output clock
//   rst_n - asynchronous active-low power-on / global reset
//   bus   - reset_sequencer_if.slave (lock/button in, resets/ready/count out)
module reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int CNT_W              = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    reset_sequencer_if.slave   bus
);

    // One timer serves both the lock-stable window and the stage gaps, so it
    // is sized for whichever is longer.
    localparam int TMR_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        STABLE     = 3'd1,
        REL_PERIPH = 3'd2,
        REL_CORE   = 3'd3,
        RUN        = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q,  btn_sync_d;
    logic [DB_W-1:0]        db_cnt_q,    db_cnt_d;
    logic                   btn_db_q,    btn_db_d;
    state_t                 state_q,     state_d;
    logic [TMR_W-1:0]       tmr_q,       tmr_d;
    logic                   periph_q,    periph_d;
    logic                   core_q,      core_d;
    logic                   ready_q,     ready_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;

    logic locked_s;
    logic btn_s;
    logic abort;

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

    // Synchronizer chains and debounce.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], bus.btn_reset};
        db_cnt_d    = db_cnt_q;
        btn_db_d    = btn_db_q;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            // Mismatch has persisted DEBOUNCE_CYCLES edges: accept new level.
            btn_db_d = btn_s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign abort = (state_q != HOLD) && (!locked_s || btn_db_q);

    // Next state and registered outputs.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        periph_d = periph_q;
        core_d   = core_q;
        ready_d  = ready_q;
        cnt_d    = cnt_q;

        if (abort) begin
            state_d  = HOLD;
            tmr_d    = '0;
            periph_d = 1'b1;
            core_d   = 1'b1;
            ready_d  = 1'b0;
            // Lock loss wins over a simultaneous button press; losses while
            // still in STABLE are just an unsettled PLL and are not counted.
            if (!locked_s && (state_q != STABLE) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                HOLD: begin
                    tmr_d    = '0;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    ready_d  = 1'b0;
                    if (locked_s && !btn_db_q) begin
                        state_d = STABLE;
                    end
                end
                STABLE: begin
                    if (tmr_q == LOCK_LAST) begin
                        state_d  = REL_PERIPH;
                        tmr_d    = '0;
                        periph_d = 1'b0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                REL_PERIPH: begin
                    if (tmr_q == GAP_LAST) begin
                        state_d = REL_CORE;
                        tmr_d   = '0;
                        core_d  = 1'b0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                REL_CORE: begin
                    if (tmr_q == GAP_LAST) begin
                        state_d = RUN;
                        tmr_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                RUN: begin
                    tmr_d = '0;
                end
                default: begin
                    state_d  = HOLD;
                    tmr_d    = '0;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '0;
            db_cnt_q    <= '0;
            btn_db_q    <= 1'b0;
            state_q     <= HOLD;
            tmr_q       <= '0;
            periph_q    <= 1'b1;
            core_q      <= 1'b1;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
            btn_sync_q  <= btn_sync_d;
            db_cnt_q    <= db_cnt_d;
            btn_db_q    <= btn_db_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            periph_q    <= periph_d;
            core_q      <= core_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.periph_reset    = periph_q;
    assign bus.core_reset      = core_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = cnt_q;
    assign bus.state_dbg       = state_q;

endmodule
